// File: rtl/cache_pkg.sv
// Shared types and derived-geometry helpers for the set-associative cache
// controller (cache_assoc_ctrl) and its LRU update block.
package cache_pkg;

    // Controller sequencing states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        FILL   = 3'd2,
        WTHRU  = 3'd3,
        FLUSH  = 3'd4
    } state_t;

    // Number of sets for a given total line count and associativity
    function automatic int calc_sets(input int total_size, input int ways);
        return total_size / ways;
    endfunction

    // Index width (address bits selecting the set)
    function automatic int calc_iw(input int total_size, input int ways);
        return $clog2(calc_sets(total_size, ways));
    endfunction

    // Tag width (remaining upper address bits)
    function automatic int calc_tw(input int ram_depth, input int total_size, input int ways);
        return $clog2(ram_depth) - calc_iw(total_size, ways);
    endfunction

    // Per-set age vector for the default 4-way geometry; the modules use the
    // equivalent parametric packed form [WAYS-1:0][AGW-1:0].
    localparam int DEF_WAYS = 4;
    localparam int DEF_AGW  = $clog2(DEF_WAYS);
    typedef logic [DEF_WAYS-1:0][DEF_AGW-1:0] age_vec_t;

endpackage

// File: rtl/cache_lru_update.sv
// Combinational age-based LRU update for one set.
// Ages form a permutation of 0..WAYS-1; age 0 is most recently used and
// age WAYS-1 is the replacement candidate.
module cache_lru_update
    import cache_pkg::*;
#(
    parameter  int WAYS = 4,
    localparam int AGW  = $clog2(WAYS)
) (
    input  logic [WAYS-1:0][AGW-1:0] age_in,
    input  logic [AGW-1:0]           way,
    output logic [WAYS-1:0][AGW-1:0] age_out,
    output logic [AGW-1:0]           lru_way
);

    // Age every way younger than the accessed one, then make the accessed way youngest
    always_comb begin
        age_out = age_in;
        for (int i = 0; i < WAYS; i++) begin
            if (age_in[i] < age_in[way]) begin
                age_out[i] = age_in[i] + {{(AGW-1){1'b0}}, 1'b1};
            end else begin
                age_out[i] = age_in[i];
            end
        end
        age_out[way] = {AGW{1'b0}};
    end

    // Locate the way currently holding the oldest age
    always_comb begin
        lru_way = {AGW{1'b0}};
        for (int i = 0; i < WAYS; i++) begin
            if (age_in[i] == AGW'(WAYS - 1)) begin
                lru_way = AGW'(i);
            end else begin
                lru_way = lru_way;
            end
        end
    end

endmodule

// File: rtl/cache_assoc_ctrl.sv
// N-way set-associative, write-through, no-write-allocate cache controller.
// Owns tag/valid/data/LRU state and sequences lookup, fill and write-through
// traffic to the backing memory with a small FSM.
// Optional macro CACHE_STATS_EN: enables saturating hit/miss counters;
// without it both counter outputs are tied to zero.
module cache_assoc_ctrl
    import cache_pkg::*;
#(
    parameter  int WAYS       = 4,
    parameter  int TOTAL_SIZE = 16,
    parameter  int RAM_DEPTH  = 256,
    parameter  int WIDTH      = 8,
    localparam int AW         = $clog2(RAM_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [AW-1:0]    req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    output logic             resp_hit,
    output logic [WIDTH-1:0] resp_data,
    output logic             mem_req,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [15:0]      hit_count,
    output logic [15:0]      miss_count
);

    localparam int SETS = calc_sets(TOTAL_SIZE, WAYS);
    localparam int IW   = calc_iw(TOTAL_SIZE, WAYS);
    localparam int TW   = calc_tw(RAM_DEPTH, TOTAL_SIZE, WAYS);
    localparam int AGW  = $clog2(WAYS);

    state_t state_r, state_n;

    // Latched request and lookup result
    logic             we_r;
    logic [AW-1:0]    addr_r;
    logic [WIDTH-1:0] wdata_r;
    logic             hit_r;
    logic [AGW-1:0]   hit_way_r;

    // Cache arrays
    logic [SETS-1:0][WAYS-1:0]            valid_r;
    logic [SETS-1:0][WAYS-1:0][TW-1:0]    tag_r;
    logic [SETS-1:0][WAYS-1:0][WIDTH-1:0] data_r;
    logic [SETS-1:0][WAYS-1:0][AGW-1:0]   age_r;

    // Registered outputs
    logic             resp_valid_r;
    logic             resp_hit_r;
    logic [WIDTH-1:0] resp_data_r;
    logic             mem_req_r;
    logic             mem_we_r;
    logic [AW-1:0]    mem_addr_r;
    logic [WIDTH-1:0] mem_wdata_r;

    // Combinational lookup / replacement signals
    logic [IW-1:0]            idx_s;
    logic [TW-1:0]            tag_s;
    logic                     hit_s;
    logic [AGW-1:0]           hit_way_s;
    logic                     inv_found_s;
    logic [AGW-1:0]           inv_way_s;
    logic [AGW-1:0]           victim_s;
    logic [AGW-1:0]           acc_way_s;
    logic [WAYS-1:0][AGW-1:0] age_new_s;
    logic [AGW-1:0]           lru_way_s;
    logic                     rd_hit_s;

    assign idx_s    = addr_r[IW-1:0];
    assign tag_s    = addr_r[AW-1:IW];
    assign rd_hit_s = hit_s & ~we_r;

    // Ready only when idle and no flush is pending; flush wins over requests
    assign req_ready = rst & (state_r == IDLE) & ~flush;

    assign resp_valid = resp_valid_r;
    assign resp_hit   = resp_hit_r;
    assign resp_data  = resp_data_r;
    assign mem_req    = mem_req_r;
    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;

    // Tag compare across the selected set; the highest matching way wins
    always_comb begin
        hit_s     = 1'b0;
        hit_way_s = {AGW{1'b0}};
        for (int w = 0; w < WAYS; w++) begin
            if (valid_r[idx_s][w] && (tag_r[idx_s][w] == tag_s)) begin
                hit_s     = 1'b1;
                hit_way_s = AGW'(w);
            end else begin
                hit_s     = hit_s;
            end
        end
    end

    // Victim: lowest-index invalid way, otherwise the oldest way of the set
    always_comb begin
        inv_found_s = 1'b0;
        inv_way_s   = {AGW{1'b0}};
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_r[idx_s][w]) begin
                inv_found_s = 1'b1;
                inv_way_s   = AGW'(w);
            end else begin
                inv_found_s = inv_found_s;
            end
        end
        if (inv_found_s) begin
            victim_s = inv_way_s;
        end else begin
            victim_s = lru_way_s;
        end
    end

    // Way presented to the LRU updater depends on which access is retiring
    always_comb begin
        if (state_r == FILL) begin
            acc_way_s = victim_s;
        end else if (state_r == LOOKUP) begin
            acc_way_s = hit_way_s;
        end else begin
            acc_way_s = hit_way_r;
        end
    end

    cache_lru_update #(
        .WAYS (WAYS)
    ) u_lru (
        .age_in  (age_r[idx_s]),
        .way     (acc_way_s),
        .age_out (age_new_s),
        .lru_way (lru_way_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (flush) begin
                    state_n = FLUSH;
                end else if (req_valid) begin
                    state_n = LOOKUP;
                end else begin
                    state_n = IDLE;
                end
            end
            LOOKUP: begin
                if (rd_hit_s) begin
                    state_n = IDLE;
                end else if (!we_r) begin
                    state_n = FILL;
                end else begin
                    state_n = WTHRU;
                end
            end
            FILL: begin
                if (mem_ack) begin
                    state_n = IDLE;
                end else begin
                    state_n = FILL;
                end
            end
            WTHRU: begin
                if (mem_ack) begin
                    state_n = IDLE;
                end else begin
                    state_n = WTHRU;
                end
            end
            FLUSH: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Capture the accepted request and the lookup outcome for later states
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_r      <= 1'b0;
            addr_r    <= {AW{1'b0}};
            wdata_r   <= {WIDTH{1'b0}};
            hit_r     <= 1'b0;
            hit_way_r <= {AGW{1'b0}};
        end else begin
            if ((state_r == IDLE) && !flush && req_valid) begin
                we_r    <= req_we;
                addr_r  <= req_addr;
                wdata_r <= req_wdata;
            end
            if (state_r == LOOKUP) begin
                hit_r     <= hit_s;
                hit_way_r <= hit_way_s;
            end
        end
    end

    // Update valid/tag/data/age arrays on hits, fills, write-through and flush
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= '0;
            tag_r   <= '0;
            data_r  <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    age_r[s][w] <= AGW'(w);
                end
            end
        end else begin
            case (state_r)
                LOOKUP: begin
                    if (rd_hit_s) begin
                        age_r[idx_s] <= age_new_s;
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        valid_r[idx_s][victim_s] <= 1'b1;
                        tag_r[idx_s][victim_s]   <= tag_s;
                        data_r[idx_s][victim_s]  <= mem_rdata;
                        age_r[idx_s]             <= age_new_s;
                    end
                end
                WTHRU: begin
                    // Write misses do not allocate and leave ages untouched
                    if (mem_ack && hit_r) begin
                        data_r[idx_s][hit_way_r] <= wdata_r;
                        age_r[idx_s]             <= age_new_s;
                    end
                end
                FLUSH: begin
                    valid_r <= '0;
                end
                default: begin
                    valid_r <= valid_r;
                end
            endcase
        end
    end

    // Registered response and memory-port outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_valid_r <= 1'b0;
            resp_hit_r   <= 1'b0;
            resp_data_r  <= {WIDTH{1'b0}};
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= {AW{1'b0}};
            mem_wdata_r  <= {WIDTH{1'b0}};
        end else begin
            resp_valid_r <= 1'b0;
            case (state_r)
                LOOKUP: begin
                    if (rd_hit_s) begin
                        resp_valid_r <= 1'b1;
                        resp_hit_r   <= 1'b1;
                        resp_data_r  <= data_r[idx_s][hit_way_s];
                    end else begin
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= we_r;
                        mem_addr_r  <= addr_r;
                        mem_wdata_r <= wdata_r;
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        mem_req_r    <= 1'b0;
                        mem_we_r     <= 1'b0;
                        resp_valid_r <= 1'b1;
                        resp_hit_r   <= 1'b0;
                        resp_data_r  <= mem_rdata;
                    end
                end
                WTHRU: begin
                    if (mem_ack) begin
                        mem_req_r    <= 1'b0;
                        mem_we_r     <= 1'b0;
                        resp_valid_r <= 1'b1;
                        resp_hit_r   <= hit_r;
                        resp_data_r  <= wdata_r;
                    end
                end
                default: begin
                    mem_req_r <= mem_req_r;
                end
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    logic [15:0] hit_cnt_r;
    logic [15:0] miss_cnt_r;

    // Saturating lookup statistics; flush does not touch them
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_r  <= 16'h0000;
            miss_cnt_r <= 16'h0000;
        end else if (state_r == LOOKUP) begin
            if (hit_s) begin
                if (hit_cnt_r != 16'hFFFF) begin
                    hit_cnt_r <= hit_cnt_r + 16'd1;
                end
            end else begin
                if (miss_cnt_r != 16'hFFFF) begin
                    miss_cnt_r <= miss_cnt_r + 16'd1;
                end
            end
        end
    end

    assign hit_count  = hit_cnt_r;
    assign miss_count = miss_cnt_r;
`else
    assign hit_count  = 16'h0000;
    assign miss_count = 16'h0000;
`endif

endmodule
